// File: rtl/kbd_rx_fifo.sv
// kbd_rx_fifo
//   Keyboard receive buffer between the PS/2 decoder and the bus read path.
//   Each non-zero ASCII code is captured on the rising edge of key_pressed
//   and queued in a small register FIFO. One code is returned for each CPU
//   bus read, using a done handshake. A pending/ack flop drives the 4-bit
//   interrupt vector.
//
//   Optional feature macro: KBD_FIFO_OVF_STATUS_EN
//     defined   : rd_data[9] reports overflow sampled at the pop, and each
//                 pop clears overflow unless a drop happens in that cycle.
//     undefined : rd_data[9] is 0, and overflow is cleared only by KEY0.
//
// Ports
//   CLOCK_50          in   system clock, rising edge
//   KEY0              in   asynchronous active-low reset
//   key_pressed       in   decoder key-pressed level (CLOCK_50 domain)
//   ascii[7:0]        in   decoder ASCII code
//   rd_en             in   bus read enable, held high until rd_done
//   rd_data[63:0]     out  {54'd0, ovf_bit, valid, code[7:0]}
//   rd_done           out  read complete, held while rd_en stays high
//   irq_ack           in   interrupt acknowledge
//   interrupt_vector  out  4'd1 while a keyboard interrupt is pending
//   count[AW:0]       out  FIFO occupancy, 0..DEPTH
//   overflow          out  sticky: a code was dropped on a full FIFO
module kbd_rx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          CLOCK_50,
  input  logic          KEY0,
  input  logic          key_pressed,
  input  logic [7:0]    ascii,
  input  logic          rd_en,
  output logic [63:0]   rd_data,
  output logic          rd_done,
  input  logic          irq_ack,
  output logic [3:0]    interrupt_vector,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          key_pressed_q;
  logic          rd_en_q;
  logic [9:0]    rd_data_q, rd_data_d;
  logic          rd_done_q, rd_done_d;
  logic          irq_pending_q, irq_pending_d;
  logic          overflow_q, overflow_d;

  logic push, pop, empty, full, push_ok, pop_ok, drop, ovf_bit;

  assign push  = key_pressed & ~key_pressed_q & (ascii != 8'h00);
  assign pop   = rd_en & ~rd_en_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);

  // A pop on a full FIFO frees a slot, so a push in the same cycle is accepted.
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign pop_ok  = pop & ~empty;

`ifdef KBD_FIFO_OVF_STATUS_EN
  assign ovf_bit = overflow_q;
`else
  assign ovf_bit = 1'b0;
`endif

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    rd_data_d     = rd_data_q;
    rd_done_d     = rd_done_q;
    irq_pending_d = irq_pending_q;
    overflow_d    = overflow_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      rd_data_d = {ovf_bit, ~empty, (empty ? 8'h00 : mem_q[rd_ptr_q])};
    end

    if (pop) begin
      rd_done_d = 1'b1;
    end else if (!rd_en) begin
      rd_done_d = 1'b0;
    end

    // A push in the same cycle as an acknowledge keeps the interrupt pending.
    if (push_ok) begin
      irq_pending_d = 1'b1;
    end else if (irq_ack) begin
      irq_pending_d = 1'b0;
    end

`ifdef KBD_FIFO_OVF_STATUS_EN
    if (drop) begin
      overflow_d = 1'b1;
    end else if (pop) begin
      overflow_d = 1'b0;
    end
`else
    if (drop) overflow_d = 1'b1;
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      key_pressed_q <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_data_q     <= '0;
      rd_done_q     <= 1'b0;
      irq_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      key_pressed_q <= key_pressed;
      rd_en_q       <= rd_en;
      rd_data_q     <= rd_data_d;
      rd_done_q     <= rd_done_d;
      irq_pending_q <= irq_pending_d;
      overflow_q    <= overflow_d;
    end
  end

  // Storage is not reset; reset only discards the entries by clearing the pointers.
  always_ff @(posedge CLOCK_50) begin
    if (push_ok) mem_q[wr_ptr_q] <= ascii;
  end

  assign rd_data          = {54'd0, rd_data_q};
  assign rd_done          = rd_done_q;
  assign interrupt_vector = {3'b000, irq_pending_q};
  assign count            = count_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_kbd_rx_fifo.sv
module tb_kbd_rx_fifo;

  logic        CLOCK_50;
  logic        KEY0;
  logic        key_pressed;
  logic [7:0]  ascii;
  logic        rd_en;
  logic [63:0] rd_data;
  logic        rd_done;
  logic        irq_ack;
  logic [3:0]  interrupt_vector;
  logic [3:0]  count;
  logic        overflow;

  int unsigned vectors;
  int unsigned miscompares;

  kbd_rx_fifo #(.DEPTH(8), .AW(3)) dut (
    .CLOCK_50         (CLOCK_50),
    .KEY0             (KEY0),
    .key_pressed      (key_pressed),
    .ascii            (ascii),
    .rd_en            (rd_en),
    .rd_data          (rd_data),
    .rd_done          (rd_done),
    .irq_ack          (irq_ack),
    .interrupt_vector (interrupt_vector),
    .count            (count),
    .overflow         (overflow)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    KEY0 = 1'b0; key_pressed = 1'b0; ascii = 8'h00; rd_en = 1'b0; irq_ack = 1'b0;
    tick();
    tick();
    KEY0 = 1'b1;
    tick();
  endtask

  task automatic press(input logic [7:0] code);
    key_pressed = 1'b1; ascii = code;
    tick();
    key_pressed = 1'b0; ascii = 8'h00;
    tick();
  endtask

  // One bus read; returns the data seen one cycle after rd_en rises.
  task automatic bus_read(output logic [63:0] data, output logic done);
    rd_en = 1'b1;
    tick();
    data = rd_data;
    done = rd_done;
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (rd_data !== 64'h0) begin miscompares++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    vectors++;
    if (rd_done !== 1'b0) begin miscompares++; $display("FAIL reset_rd_done got=%b exp=0", rd_done); end
    vectors++;
    if (interrupt_vector !== 4'd0) begin miscompares++; $display("FAIL reset_irq got=%0d exp=0", interrupt_vector); end
    vectors++;
    if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_single();
    do_reset();
    key_pressed = 1'b1; ascii = 8'h41;
    tick();
    vectors++;
    if (count !== 4'd1) begin miscompares++; $display("FAIL single_count got=%0d exp=1", count); end
    vectors++;
    if (interrupt_vector !== 4'd1) begin miscompares++; $display("FAIL single_irq got=%0d exp=1", interrupt_vector); end
    key_pressed = 1'b0; ascii = 8'h00;
    tick();
    rd_en = 1'b1;
    tick();
    vectors++;
    if (rd_data !== 64'h141) begin miscompares++; $display("FAIL single_rd_data got=%h exp=141", rd_data); end
    vectors++;
    if (rd_done !== 1'b1) begin miscompares++; $display("FAIL single_rd_done got=%b exp=1", rd_done); end
    vectors++;
    if (count !== 4'd0) begin miscompares++; $display("FAIL single_count_after got=%0d exp=0", count); end
    rd_en = 1'b0;
    tick();
    vectors++;
    if (rd_done !== 1'b0) begin miscompares++; $display("FAIL single_done_fall got=%b exp=0", rd_done); end
    vectors++;
    if (rd_data !== 64'h141) begin miscompares++; $display("FAIL single_data_hold got=%h exp=141", rd_data); end
  endtask

  task automatic test_hold();
    logic [63:0] d;
    logic        dn;
    do_reset();
    press(8'h61);
    press(8'h62);
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (rd_done !== 1'b1) begin miscompares++; $display("FAIL hold_done cyc=%0d got=%b exp=1", i, rd_done); end
    end
    vectors++;
    if (count !== 4'd1) begin miscompares++; $display("FAIL hold_count got=%0d exp=1", count); end
    vectors++;
    if (rd_data !== 64'h161) begin miscompares++; $display("FAIL hold_rd_data got=%h exp=161", rd_data); end
    rd_en = 1'b0;
    tick();
    vectors++;
    if (rd_done !== 1'b0) begin miscompares++; $display("FAIL hold_done_fall got=%b exp=0", rd_done); end
    bus_read(d, dn);
    vectors++;
    if (d !== 64'h162) begin miscompares++; $display("FAIL hold_second_read got=%h exp=162", d); end
    vectors++;
    if (count !== 4'd0) begin miscompares++; $display("FAIL hold_drained got=%0d exp=0", count); end
  endtask

  task automatic test_full_overflow();
    logic [63:0] d;
    logic        dn;
    logic [63:0] exp;
    do_reset();
    for (int i = 0; i < 8; i++) press(8'h31 + 8'(i));
    vectors++;
    if (count !== 4'd8) begin miscompares++; $display("FAIL full_count got=%0d exp=8", count); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL full_no_ovf got=%b exp=0", overflow); end
    press(8'h39);
    vectors++;
    if (count !== 4'd8) begin miscompares++; $display("FAIL drop_count got=%0d exp=8", count); end
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL drop_ovf got=%b exp=1", overflow); end
    for (int i = 0; i < 8; i++) begin
      bus_read(d, dn);
      exp = 64'h100 + 64'(8'h31 + 8'(i));
`ifdef KBD_FIFO_OVF_STATUS_EN
      if (i == 0) exp = exp | 64'h200;
`endif
      vectors++;
      if (d !== exp) begin miscompares++; $display("FAIL drain_read idx=%0d got=%h exp=%h", i, d, exp); end
    end
    vectors++;
`ifdef KBD_FIFO_OVF_STATUS_EN
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_after_reads got=%b exp=0", overflow); end
`else
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_after_reads got=%b exp=1", overflow); end
`endif
    bus_read(d, dn);
    vectors++;
    if (d !== 64'h0) begin miscompares++; $display("FAIL empty_read got=%h exp=0", d); end
    vectors++;
    if (dn !== 1'b1) begin miscompares++; $display("FAIL empty_read_done got=%b exp=1", dn); end
  endtask

  task automatic test_full_push_pop();
    logic [63:0] d;
    logic        dn;
    logic [7:0]  exp_codes [8];
    do_reset();
    for (int i = 0; i < 8; i++) press(8'h41 + 8'(i));
    key_pressed = 1'b1; ascii = 8'h5A; rd_en = 1'b1;
    tick();
    vectors++;
    if (rd_data !== 64'h141) begin miscompares++; $display("FAIL pp_rd_data got=%h exp=141", rd_data); end
    vectors++;
    if (count !== 4'd8) begin miscompares++; $display("FAIL pp_count got=%0d exp=8", count); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL pp_ovf got=%b exp=0", overflow); end
    key_pressed = 1'b0; ascii = 8'h00; rd_en = 1'b0;
    tick();
    exp_codes = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h5A};
    for (int i = 0; i < 8; i++) begin
      bus_read(d, dn);
      vectors++;
      if (d !== (64'h100 | 64'(exp_codes[i]))) begin
        miscompares++;
        $display("FAIL pp_drain idx=%0d got=%h exp=%h", i, d, 64'h100 | 64'(exp_codes[i]));
      end
    end
    vectors++;
    if (count !== 4'd0) begin miscompares++; $display("FAIL pp_drained got=%0d exp=0", count); end
  endtask

  task automatic test_irq();
    do_reset();
    press(8'h41);
    key_pressed = 1'b1; ascii = 8'h42; irq_ack = 1'b1;
    tick();
    vectors++;
    if (interrupt_vector !== 4'd1) begin miscompares++; $display("FAIL irq_push_wins got=%0d exp=1", interrupt_vector); end
    vectors++;
    if (count !== 4'd2) begin miscompares++; $display("FAIL irq_push_count got=%0d exp=2", count); end
    key_pressed = 1'b0; ascii = 8'h00;
    tick();
    vectors++;
    if (interrupt_vector !== 4'd0) begin miscompares++; $display("FAIL irq_ack_clear got=%0d exp=0", interrupt_vector); end
    irq_ack = 1'b0;
    key_pressed = 1'b1; ascii = 8'h00;
    tick();
    key_pressed = 1'b0;
    tick();
    tick();
    vectors++;
    if (count !== 4'd2) begin miscompares++; $display("FAIL zero_code_count got=%0d exp=2", count); end
    vectors++;
    if (interrupt_vector !== 4'd0) begin miscompares++; $display("FAIL zero_code_irq got=%0d exp=0", interrupt_vector); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    logic        dn;
    do_reset();
    for (int i = 0; i < 9; i++) press(8'h70 + 8'(i));
    for (int i = 0; i < 5; i++) bus_read(d, dn);
    vectors++;
    if (count !== 4'd3) begin miscompares++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
    rd_en = 1'b1;
    tick();
    #2;
    KEY0 = 1'b0;
    #1;
    vectors++;
    if (rd_data !== 64'h0) begin miscompares++; $display("FAIL mid_rst_rd_data got=%h exp=0", rd_data); end
    vectors++;
    if (rd_done !== 1'b0) begin miscompares++; $display("FAIL mid_rst_done got=%b exp=0", rd_done); end
    vectors++;
    if (count !== 4'd0) begin miscompares++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ovf got=%b exp=0", overflow); end
    vectors++;
    if (interrupt_vector !== 4'd0) begin miscompares++; $display("FAIL mid_rst_irq got=%0d exp=0", interrupt_vector); end
    rd_en = 1'b0;
    tick();
    KEY0 = 1'b1;
    tick();
    bus_read(d, dn);
    vectors++;
    if (d !== 64'h0) begin miscompares++; $display("FAIL mid_post_read got=%h exp=0", d); end
    vectors++;
    if (dn !== 1'b1) begin miscompares++; $display("FAIL mid_post_done got=%b exp=1", dn); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    KEY0 = 1'b0; key_pressed = 1'b0; ascii = 8'h00; rd_en = 1'b0; irq_ack = 1'b0;
    test_reset();
    test_single();
    test_hold();
    test_full_overflow();
    test_full_push_pop();
    test_irq();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
